// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

package ram_arb_pkg;
    localparam int RAM_AW          = `RAM_ADDRESS_BITWIDTH;
    localparam int WORD_ALIGN_BITS = 2;

    typedef enum logic {OWN_REQ0 = 1'b0, OWN_REQ1 = 1'b1} owner_t;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [31:0]       wdata;
    } ram_req_t;

    function automatic logic is_aligned(input logic [RAM_AW-1:0] addr);
        return addr[WORD_ALIGN_BITS-1:0] == '0;
    endfunction
endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// Two-way round-robin grant with a cap on consecutive grants to one requester.
//  state      | meaning
//  rr_ptr     | requester preferred on the next contended cycle
//  last_owner | requester granted most recently
//  burst_cnt  | consecutive grants to last_owner, saturating at MAX_BURST
module rr_grant2
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    localparam int BW = $clog2(MAX_BURST + 1);

    owner_t          rr_ptr, rr_ptr_nxt;
    owner_t          last_owner, last_owner_nxt;
    logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
    owner_t          gnt_owner;
    logic            any_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= OWN_REQ0;
            last_owner <= OWN_REQ0;
            burst_cnt  <= '0;
        end else begin
            rr_ptr     <= rr_ptr_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    always_comb begin
        any_grant      = |valid;
        gnt_owner      = rr_ptr;
        rr_ptr_nxt     = rr_ptr;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        if (valid == 2'b01) begin
            gnt_owner = OWN_REQ0;
        end else if (valid == 2'b10) begin
            gnt_owner = OWN_REQ1;
        end else if (valid == 2'b11 && burst_cnt == BW'(MAX_BURST)) begin
            gnt_owner = owner_t'(~last_owner);
        end
        if (any_grant) begin
            rr_ptr_nxt     = owner_t'(~gnt_owner);
            last_owner_nxt = gnt_owner;
            if (gnt_owner != last_owner) begin
                burst_cnt_nxt = BW'(1);
            end else if (burst_cnt != BW'(MAX_BURST)) begin
                burst_cnt_nxt = burst_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        grant = 2'b00;
        if (any_grant) begin
            grant = (gnt_owner == OWN_REQ1) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the load/store unit (port 0) and the loader (port 1),
// with a one-stage response pipe that returns every accepted request exactly one cycle later.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = RAM_AW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [31:0]   req0_wdata,
    output logic          rsp0_valid,
    output logic [31:0]   rsp0_rdata,
    output logic          rsp0_err,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [31:0]   req1_wdata,
    output logic          rsp1_valid,
    output logic [31:0]   rsp1_rdata,
    output logic          rsp1_err,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_address,
    output logic [31:0]   ram_write_data,
    input  logic [31:0]   ram_data
);
    logic [1:0]     grant;
    ram_req_t       req0, req1, sel;
    owner_t         sel_owner;
    logic           accept;
    logic           aligned;
    logic [AW-1:0]  addr_q;
    logic           pend;
    owner_t         rsp_owner;
    logic           rsp_is_read;
    logic           rsp_err;
    logic           rsp_live;
    logic [31:0]    rsp_rdata;

    rr_grant2 #(.MAX_BURST(MAX_BURST)) u_rr_grant2 (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_comb begin
        req0 = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
        req1 = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
        sel       = grant[1] ? req1 : req0;
        sel_owner = grant[1] ? OWN_REQ1 : OWN_REQ0;
    end

    assign req0_ready = grant[0] && !rst;
    assign req1_ready = grant[1] && !rst;
    assign accept     = req0_ready || req1_ready;
    assign aligned    = is_aligned(sel.addr);

    // The address is held between accepts so the RAM sees a stable port when idle.
    assign ram_wr_en      = accept && sel.we && aligned;
    assign ram_address    = accept ? {sel.addr[AW-1:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}} : addr_q;
    assign ram_write_data = sel.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            pend        <= 1'b0;
            rsp_owner   <= OWN_REQ0;
            rsp_is_read <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) begin
                addr_q      <= ram_address;
                rsp_owner   <= sel_owner;
                rsp_is_read <= !sel.we;
                rsp_err     <= !aligned;
            end
        end
    end

    // A response pending when rst arrives is dropped rather than delivered.
    assign rsp_live  = pend && !rst;
    assign rsp_rdata = (rsp_is_read && !rsp_err) ? ram_data : 32'h0;

    assign rsp0_valid = rsp_live && (rsp_owner == OWN_REQ0);
    assign rsp1_valid = rsp_live && (rsp_owner == OWN_REQ1);
    assign rsp0_rdata = rsp0_valid ? rsp_rdata : 32'h0;
    assign rsp1_rdata = rsp1_valid ? rsp_rdata : 32'h0;
    assign rsp0_err   = rsp0_valid && rsp_err;
    assign rsp1_err   = rsp1_valid && rsp_err;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, shadow-memory scoreboard, grant table and corner sequences.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW    = RAM_AW;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [31:0]   req0_wdata;
    logic          rsp0_valid, rsp0_err;
    logic [31:0]   rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [31:0]   req1_wdata;
    logic          rsp1_valid, rsp1_err;
    logic [31:0]   rsp1_rdata;
    logic          ram_wr_en;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] mem    [WORDS];
    logic [31:0] shadow [WORDS];

    typedef struct {
        int          port;
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [31:0]   d1;
        logic          g0, g1;
    } row_t;
    row_t rows[$];

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_wr_en(ram_wr_en), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_address[AW-1:2]] <= ram_write_data;
        ram_data <= mem[ram_address[AW-1:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: responses are popped first, then the current accept is pushed.
    logic          mv, me, a0, a1, s_we;
    logic [31:0]   md, s_d;
    logic [AW-1:0] s_a;
    exp_t          x;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_ram_wr_en", ram_wr_en, 0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                mv = (p == 0) ? rsp0_valid : rsp1_valid;
                me = (p == 0) ? rsp0_err   : rsp1_err;
                md = (p == 0) ? rsp0_rdata : rsp1_rdata;
                if (sb.size() > 0 && sb[0].due == cyc && sb[0].port == p) begin
                    x = sb.pop_front();
                    chk($sformatf("rsp%0d_valid", p), mv, 1);
                    chk($sformatf("rsp%0d_err", p), me, x.err);
                    chk($sformatf("rsp%0d_rdata", p), md, x.rdata);
                end else begin
                    chk($sformatf("rsp%0d_spurious", p), mv, 0);
                end
            end
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            chk("one_ready", a0 && a1, 0);
            if (a0 || a1) begin
                s_we = a1 ? req1_we    : req0_we;
                s_a  = a1 ? req1_addr  : req0_addr;
                s_d  = a1 ? req1_wdata : req0_wdata;
                chk("ram_wr_en", ram_wr_en, s_we && (s_a[1:0] == 2'b00));
                chk("ram_address", ram_address, {s_a[AW-1:2], 2'b00});
                if (s_we && s_a[1:0] == 2'b00) begin
                    chk("ram_write_data", ram_write_data, s_d);
                    shadow[s_a[AW-1:2]] = s_d;
                end
                x.port  = a1 ? 1 : 0;
                x.due   = cyc + 1;
                x.err   = (s_a[1:0] != 2'b00);
                x.rdata = (!s_we && s_a[1:0] == 2'b00) ? shadow[s_a[AW-1:2]] : 32'h0;
                sb.push_back(x);
            end else begin
                chk("idle_ram_wr_en", ram_wr_en, 0);
            end
        end
    end

    function automatic row_t mk(input logic v0, input logic we0, input logic [AW-1:0] ad0,
                                input logic [31:0] d0, input logic v1, input logic we1,
                                input logic [AW-1:0] ad1, input logic [31:0] d1,
                                input logic g0, input logic g1);
        row_t r;
        r.v0 = v0; r.we0 = we0; r.a0 = ad0; r.d0 = d0;
        r.v1 = v1; r.we1 = we1; r.a1 = ad1; r.d1 = d1;
        r.g0 = g0; r.g1 = g1;
        return r;
    endfunction

    function automatic row_t both(input int g);
        return mk(1, 1, AW'(16'h40), 32'hAAAA_0000, 1, 0, AW'(16'h40), 32'h0, g == 0, g == 1);
    endfunction

    function automatic row_t one(input int p, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        if (p == 0) return mk(1, we, a, d, 0, 0, '0, 32'h0, 1, 0);
        return mk(0, 0, '0, 32'h0, 1, we, a, d, 0, 1);
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk); #1;
            req0_valid = rows[i].v0; req0_we = rows[i].we0; req0_addr = rows[i].a0; req0_wdata = rows[i].d0;
            req1_valid = rows[i].v1; req1_we = rows[i].we1; req1_addr = rows[i].a1; req1_wdata = rows[i].d1;
            @(negedge clk);
            chk($sformatf("row%0d_ready0", i), req0_ready, rows[i].g0);
            chk($sformatf("row%0d_ready1", i), req1_ready, rows[i].g1);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        logic got;
        got = 0;
        @(posedge clk); #1;
        if (p == 0) begin
            req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        if (!got) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        idle_inputs();
        rst = 1;

        // Reset with both requesters writing: nothing may be granted or written.
        req0_valid = 1; req0_we = 1; req0_addr = AW'(16'h10); req0_wdata = 32'h0000_0BAD;
        req1_valid = 1; req1_we = 1; req1_addr = AW'(16'h14); req1_wdata = 32'h0000_0BAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ready0", req0_ready, 0);
            chk("reset_ready1", req1_ready, 0);
            chk("reset_wr_en", ram_wr_en, 0);
        end
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();

        // Write then read back on port 0.
        issue(0, 1, AW'(16'h10), 32'h0000_1234);
        @(negedge clk);
        chk("wr_ack_valid", rsp0_valid, 1);
        chk("wr_ack_err", rsp0_err, 0);
        issue(0, 0, AW'(16'h10), 32'h0);
        @(negedge clk);
        chk("rd_valid", rsp0_valid, 1);
        chk("rd_rdata", rsp0_rdata, 32'h0000_1234);

        // Misaligned write on port 1 must not touch the RAM.
        issue(1, 1, AW'(16'h13), 32'hDEAD_BEEF);
        @(negedge clk);
        chk("mis_valid", rsp1_valid, 1);
        chk("mis_err", rsp1_err, 1);
        chk("mis_rdata", rsp1_rdata, 32'h0);
        issue(0, 0, AW'(16'h10), 32'h0);
        @(negedge clk);
        chk("mis_old_data", rsp0_rdata, 32'h0000_1234);

        // Reset in the cycle after a read accept drops its response.
        issue(0, 0, AW'(16'h10), 32'h0);
        rst = 1;
        @(negedge clk);
        chk("midrst_rsp0", rsp0_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        req0_valid = 1; req0_addr = AW'(16'h10);
        req1_valid = 1; req1_addr = AW'(16'h14);
        @(negedge clk);
        chk("midrst_pref0", req0_ready, 1);
        chk("midrst_pref1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("midrst_then1", req1_ready, 1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("midrst_ram_kept", rsp1_rdata, 32'h0);

        // Fresh reset so the contention table starts with req0 preferred.
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 10; i++) rows.push_back(both(i % 2));
        for (int i = 0; i < 4; i++)  rows.push_back(mk(1, 1, AW'(16'h40), 32'hAAAA_0000, 0, 0, '0, 32'h0, 1, 0));
        rows.push_back(both(1));
        rows.push_back(both(0));

        rows.push_back(one(0, 1, AW'(16'h100), 32'h1111_1111));
        rows.push_back(one(1, 1, AW'(16'h104), 32'h2222_2222));
        rows.push_back(one(0, 0, AW'(16'h104), 32'h0));
        rows.push_back(one(1, 0, AW'(16'h100), 32'h0));
        rows.push_back(one(0, 1, AW'(16'h108), 32'h3333_3333));
        rows.push_back(one(1, 0, AW'(16'h108), 32'h0));
        rows.push_back(one(0, 0, AW'(16'h108), 32'h0));
        rows.push_back(one(1, 1, AW'(16'h100), 32'h4444_4444));
        rows.push_back(one(0, 0, AW'(16'h100), 32'h0));
        rows.push_back(one(1, 0, AW'(16'h104), 32'h0));
        rows.push_back(one(0, 1, AW'(16'h10C), 32'h5555_5555));
        rows.push_back(one(1, 1, AW'(16'h10C), 32'h6666_6666));
        rows.push_back(one(0, 0, AW'(16'h10C), 32'h0));
        rows.push_back(one(1, 0, AW'(16'h102), 32'h0));
        rows.push_back(one(0, 1, AW'(16'h101), 32'h7777_7777));
        rows.push_back(one(1, 0, AW'(16'h100), 32'h0));

        run_rows(0, 16);
        run_rows(16, 32);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        chk("final_mem_100", shadow[AW'(16'h100) >> 2], 32'h4444_4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
